// File: rtl/bcd_countdown_display_if.sv
// Control and display bundle for the BCD countdown timer.
// Signalling: there is no valid/ready pair. run is a level sampled on every
// rising clock edge, load is a one-cycle pulse sampled on the edge it is high,
// and every output is valid on every cycle once reset has been released.
interface bcd_countdown_display_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    run;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] preset;
    logic                    a, b, c, d, e, f, g;
    logic                    dp;
    logic [7:0]              an;
    logic                    game_over;
    logic [4*NUM_DIGITS-1:0] value;
    logic [31:0]             dbg_presc;
    logic [31:0]             dbg_scan;
    logic                    dbg_blink_phase;

    modport master (
        output run, load, preset,
        input  a, b, c, d, e, f, g, dp, an, game_over, value,
        input  dbg_presc, dbg_scan, dbg_blink_phase
    );

    modport slave (
        input  run, load, preset,
        output a, b, c, d, e, f, g, dp, an, game_over, value,
        output dbg_presc, dbg_scan, dbg_blink_phase
    );
endinterface

// File: rtl/bcd_countdown_display.sv
// Packed-BCD countdown timer with a multiplexed 7-segment driver, run/pause,
// preset load, leading-zero blanking and blink once the count expires.
module bcd_countdown_display #(
    parameter int          TICK_DIV   = 5000,
    parameter int          NUM_DIGITS = 8,
    parameter logic [31:0] INIT_BCD   = 32'h0018_0000,
    parameter int          SCAN_BITS  = 6,
    parameter int          DP_POS     = 4,
    parameter int          BLINK_BITS = 4
) (
    input  logic clock,
    input  logic reset,
    bcd_countdown_display_if.slave bus
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = BLINK_BITS + 1;
    localparam logic [PW-1:0] PMAX     = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]  INIT_VAL = INIT_BCD[W-1:0];

    logic [W-1:0]           r_value;
    logic                   r_game_over;
    logic [PW-1:0]          r_presc;
    logic [BW-1:0]          r_blink;
    logic [SCAN_BITS-1:0]   r_scan;

    logic                   w_tick;
    logic [W-1:0]           w_dec;
    logic [W-1:0]           w_clamp;
    logic [2:0]             w_k;
    logic                   w_phase;
    logic [NUM_DIGITS-1:0]  w_blank_vec;
    logic [3:0]             w_digit;
    logic                   w_blank_sel;
    logic                   w_k_valid;
    logic [6:0]             w_lut;
    logic [6:0]             w_seg;
    logic [7:0]             w_an;
    logic                   w_dp;

    // The prescaler only advances while running or expired (expired keeps blink alive).
    assign w_tick = (bus.run | r_game_over) & (r_presc == PMAX);

    // Ripple-borrow BCD decrement: a zero digit borrows and becomes 9.
    always_comb begin
        logic v_borrow;
        w_dec    = r_value;
        v_borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v_borrow) begin
                if (r_value[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = r_value[4*i +: 4] - 4'd1;
                    v_borrow        = 1'b0;
                end
            end
        end
    end

    // Non-decimal preset digits are clamped to 9.
    always_comb begin
        w_clamp = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_clamp[4*i +: 4] = (bus.preset[4*i +: 4] > 4'd9) ? 4'd9 : bus.preset[4*i +: 4];
        end
    end

    // Count, expiry flag, prescaler and blink counter; load wins over tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_value     <= INIT_VAL;
            r_game_over <= (INIT_VAL == '0);
            r_presc     <= '0;
            r_blink     <= '0;
        end else if (bus.load) begin
            r_value     <= w_clamp;
            r_game_over <= (w_clamp == '0);
            r_presc     <= '0;
            r_blink     <= '0;
        end else begin
            if (bus.run | r_game_over) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            end
            if (w_tick) begin
                if (r_game_over) begin
                    r_blink <= r_blink + BW'(1);
                end else begin
                    r_value     <= w_dec;
                    r_game_over <= (w_dec == '0);
                end
            end
        end
    end

    // Free-running refresh counter for the digit multiplexer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scan <= '0;
        end else begin
            r_scan <= r_scan + SCAN_BITS'(1);
        end
    end

    assign w_k     = r_scan[SCAN_BITS-1 -: 3];
    assign w_phase = r_blink[BLINK_BITS];

    // Leading-zero blanking from the top digit down, then select the scanned digit.
    always_comb begin
        logic v_nz;
        v_nz        = 1'b0;
        w_blank_vec = '0;
        w_digit     = 4'd0;
        w_blank_sel = 1'b0;
        w_k_valid   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_nz           = v_nz | (r_value[4*i +: 4] != 4'd0);
            w_blank_vec[i] = (i > DP_POS) && !v_nz;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(w_k) == i) begin
                w_digit     = r_value[4*i +: 4];
                w_blank_sel = w_blank_vec[i];
                w_k_valid   = 1'b1;
            end
        end
    end

    // Digit to segment pattern, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        case (w_digit)
            4'd0:    w_lut = 7'h3F;
            4'd1:    w_lut = 7'h06;
            4'd2:    w_lut = 7'h5B;
            4'd3:    w_lut = 7'h4F;
            4'd4:    w_lut = 7'h66;
            4'd5:    w_lut = 7'h6D;
            4'd6:    w_lut = 7'h7D;
            4'd7:    w_lut = 7'h07;
            4'd8:    w_lut = 7'h7F;
            4'd9:    w_lut = 7'h6F;
            default: w_lut = 7'h00;
        endcase
    end

    // Anodes keep scanning during blink; only segments and dp go dark.
    always_comb begin
        w_an  = w_k_valid ? ~(8'b1 << w_k) : 8'hFF;
        w_seg = (w_k_valid && !w_blank_sel && !w_phase) ? w_lut : 7'h00;
        w_dp  = (int'(w_k) == DP_POS) && !w_phase;
    end

    assign {bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = w_seg;
    assign bus.dp              = w_dp;
    assign bus.an              = w_an;
    assign bus.game_over       = r_game_over;
    assign bus.value           = r_value;
    assign bus.dbg_presc       = 32'(r_presc);
    assign bus.dbg_scan        = 32'(r_scan);
    assign bus.dbg_blink_phase = w_phase;
endmodule

// File: tb/tb_bcd_countdown_display.sv
// Scoreboard bench for bcd_countdown_display with a decimal reference model.
module tb_bcd_countdown_display;
    localparam int TD = 4;
    localparam int ND = 4;
    localparam int SB = 3;
    localparam int DP = 1;
    localparam int BB = 1;
    localparam int EW = 33;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bcd_countdown_display_if #(.NUM_DIGITS(ND)) bus ();

    bcd_countdown_display #(
        .TICK_DIV   (TD),
        .NUM_DIGITS (ND),
        .INIT_BCD   (32'h0000_0012),
        .SCAN_BITS  (SB),
        .DP_POS     (DP),
        .BLINK_BITS (BB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [6:0] seg_lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model: count kept as a plain decimal integer.
    int m_v, m_presc, m_blink, m_scan;
    bit m_go;

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic int clamp_preset(input logic [15:0] p);
        int s = 0;
        for (int i = 0; i < ND; i++) begin
            int dg = int'((p >> (4 * i)) & 16'hF);
            if (dg > 9) dg = 9;
            s = s + dg * pow10(i);
        end
        return s;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < ND; i++) r = r | 16'(((v / pow10(i)) % 10) << (4 * i));
        return r;
    endfunction

    function automatic logic [EW-1:0] expect_out();
        int k, dg;
        bit phase, blank;
        logic [7:0] an;
        logic [6:0] seg;
        logic dp;
        k     = (m_scan >> (SB - 3)) & 7;
        phase = ((m_blink >> BB) & 1) != 0;
        an    = (k < ND) ? 8'(~(32'd1 << k)) : 8'hFF;
        dg    = (m_v / pow10(k)) % 10;
        blank = (k > DP) && (m_v < pow10(k));
        seg   = (k < ND && !blank && !phase) ? seg_lut[dg] : 7'h00;
        dp    = (k == DP) && !phase;
        return {to_bcd(m_v), m_go, an, seg, dp};
    endfunction

    task automatic model_reset();
        m_v = 12; m_go = 0; m_presc = 0; m_blink = 0; m_scan = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic l, input logic [15:0] p);
        bit tick;
        bus.run = r; bus.load = l; bus.preset = p;
        tick = (r || m_go) && (m_presc == TD - 1);
        if (l) begin
            m_v = clamp_preset(p); m_go = (m_v == 0); m_presc = 0; m_blink = 0;
        end else begin
            if (r || m_go) m_presc = tick ? 0 : m_presc + 1;
            if (tick) begin
                if (m_go) m_blink++;
                else begin
                    m_v--;
                    if (m_v == 0) m_go = 1;
                end
            end
        end
        m_scan = (m_scan + 1) % (1 << SB);
        exp_q.push_back(expect_out());
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin #1; n++; end
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            logic r, l;
            logic [15:0] p;
            r = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 29) == 0);
            p = ($urandom_range(0, 1) == 0) ? {12'h000, 4'($urandom)} : 16'($urandom);
            step(r, l, p);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clock);
            #3;
            if (!reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("value", 32'(bus.value), 32'(e[32:17]));
                check("game_over", 32'(bus.game_over), 32'(e[16]));
                check("an", 32'(bus.an), 32'(e[15:8]));
                check("seg", 32'({bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a}), 32'(e[7:1]));
                check("dp", 32'(bus.dp), 32'(e[0]));
            end
        end
    end

    // ---------------- stimulus sequence ----------------
    initial begin
        reset = 1'b1;
        bus.run = 1'b0; bus.load = 1'b0; bus.preset = '0;
        model_reset();
        #2;
        check("rst_value", 32'(bus.value), 32'h0012);
        check("rst_game_over", 32'(bus.game_over), 32'd0);
        check("rst_an", 32'(bus.an), 32'hFE);
        check("rst_seg", 32'({bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a}), 32'h5B);
        check("rst_presc", bus.dbg_presc, 32'd0);
        check("rst_scan", bus.dbg_scan, 32'd0);
        #20;
        reset = 1'b0;

        repeat (4)  step(1'b1, 1'b0, 16'h0);        // one tick -> 0011
        repeat (20) step(1'b0, 1'b0, 16'h0);        // paused, holds
        step(1'b0, 1'b1, 16'h1000);
        repeat (12) step(1'b1, 1'b0, 16'h0);        // 0999, 0998, ...
        step(1'b0, 1'b1, 16'h0001);
        repeat (4)  step(1'b1, 1'b0, 16'h0);        // expiry on the tick edge
        repeat (24) step(1'b0, 1'b0, 16'h0);        // expired: blinking, no wrap
        step(1'b0, 1'b1, 16'h00FA);                 // clamps to 0099
        repeat (3)  step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0000);                 // zero preset expires at once
        repeat (3)  step(1'b0, 1'b0, 16'h0);

        rand_steps(600);

        // Reset mid-count while the prescaler is part way through a tick.
        step(1'b0, 1'b1, 16'h0007);
        for (int i = 0; i < 100 && !(m_v == 5 && m_presc == 2); i++) step(1'b1, 1'b0, 16'h0);
        check("pre_reset_reached", 32'(m_v * 16 + m_presc), 32'(5 * 16 + 2));
        drain();
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_value", 32'(bus.value), 32'h0012);
        check("mid_rst_game_over", 32'(bus.game_over), 32'd0);
        check("mid_rst_presc", bus.dbg_presc, 32'd0);
        check("mid_rst_scan", bus.dbg_scan, 32'd0);
        bus.run = 1'b0; bus.load = 1'b0;
        model_reset();
        #20;
        reset = 1'b0;

        rand_steps(200);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
